// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
//   BYTE_W       - width of one transmitted byte
//   NREQ_DEFAULT - default number of byte producers
//   TX_IDLE      - value of tx_status while the transmitter is idle
//   state_t      - arbiter FSM state encoding
package uart_pkg;

  localparam int   BYTE_W       = 8;
  localparam int   NREQ_DEFAULT = 4;
  localparam logic TX_IDLE      = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
//   req        in  NREQ   pending requests
//   ptr        in  IDX_W  index of the last granted requester
//   gnt_onehot out NREQ   one-hot winner (0 when nothing pending)
//   gnt_idx    out IDX_W  binary index of the winner
//   any        out 1      at least one request pending
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] w_idx;

  // Search starts one past the last winner and wraps, so the last winner
  // is examined last.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_onehot[w_idx] = 1'b1;
        gnt_idx           = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte producers.
//   sysclk    in  1         clock, transmitter domain
//   reset     in  1         asynchronous active-low reset
//   req       in  NREQ      level requests
//   req_data  in  8*NREQ    byte of requester i at [8i+7:8i]
//   ack       out NREQ      one-cycle one-hot accept pulse
//   owner     out NREQ      one-hot requester whose byte is in flight
//   tx_en     out 1         transmitter start request
//   tx_data   out 8         byte presented to the transmitter
//   tx_status in  1         1 = transmitter idle, 0 = sending
//   busy      out 1         arbiter not idle
//   err       out 1         sticky start-timeout flag
//   err_clr   in  1         synchronous clear of err
//
// state | meaning
// IDLE  | waiting for a request while the transmitter is idle
// START | tx_en held, waiting for the transmitter to go busy
// SEND  | transmitter sending, waiting for it to return idle
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        owner,
  output logic                   tx_en,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_status,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int               IDX_W    = $clog2(NREQ);
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             r_state,   w_state_nxt;
  logic [IDX_W-1:0]   r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [NREQ-1:0]    r_ack,     w_ack_nxt;
  logic [NREQ-1:0]    r_owner,   w_owner_nxt;
  logic               r_tx_en,   w_tx_en_nxt;
  logic [BYTE_W-1:0]  r_tx_data, w_tx_data_nxt;
  logic               r_err,     w_err_nxt;

  logic [NREQ-1:0]    w_gnt_onehot;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic [BYTE_W-1:0]  w_gnt_byte;

  uart_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req        (req),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // AND-OR mux keyed by the one-hot grant.
  always_comb begin
    w_gnt_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_onehot[i]) w_gnt_byte = w_gnt_byte | req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_ack_nxt     = '0;
    w_owner_nxt   = r_owner;
    w_tx_en_nxt   = r_tx_en;
    w_tx_data_nxt = r_tx_data;
    // Clear first so a timeout on the same edge overrides it.
    w_err_nxt     = err_clr ? 1'b0 : r_err;
    case (r_state)
      IDLE: begin
        if (tx_status == TX_IDLE && w_any) begin
          w_tx_data_nxt = w_gnt_byte;
          w_ack_nxt     = w_gnt_onehot;
          w_owner_nxt   = w_gnt_onehot;
          w_tx_en_nxt   = 1'b1;
          w_ptr_nxt     = w_gnt_idx;
          w_cnt_nxt     = '0;
          w_state_nxt   = START;
        end
      end
      START: begin
        if (tx_status != TX_IDLE) begin
          w_tx_en_nxt = 1'b0;
          w_state_nxt = SEND;
        end else if (r_cnt == CNT_LAST) begin
          // Transmitter never started: drop the byte without re-acking.
          w_tx_en_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_owner_nxt = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SEND: begin
        if (tx_status == TX_IDLE) begin
          w_owner_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_tx_en_nxt = 1'b0;
        w_owner_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ptr     <= IDX_W'(NREQ - 1);
      r_cnt     <= '0;
      r_ack     <= '0;
      r_owner   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ack     <= w_ack_nxt;
      r_owner   <= w_owner_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign ack     = r_ack;
  assign owner   = r_owner;
  assign tx_en   = r_tx_en;
  assign tx_data = r_tx_data;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, TIMEOUT=64). Inputs change
// and outputs are sampled 1 time unit after the rising edge.
module tb_uart_tx_arbiter;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  owner;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_status;
  logic        busy;
  logic        err;
  logic        err_clr;

  int n_checks = 0;
  int n_err    = 0;
  int ack_cnt;

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .owner     (owner),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_status (tx_status),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    req       = 4'b0000;
    req_data  = 32'h0;
    tx_status = 1'b1;
    err_clr   = 1'b0;
    #1;
    chk("rst_tx_en",   tx_en,   0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ack",     ack,     4'b0000);
    chk("rst_owner",   owner,   4'b0000);
    chk("rst_busy",    busy,    0);
    chk("rst_err",     err,     0);
    tick();
    reset = 1'b1;

    // Single request
    req      = 4'b0001;
    req_data = 32'h0000_0041;
    tick();
    chk("s_ack",     ack,     4'b0001);
    chk("s_tx_en",   tx_en,   1);
    chk("s_tx_data", tx_data, 8'h41);
    chk("s_owner",   owner,   4'b0001);
    chk("s_busy",    busy,    1);
    req = 4'b0000;
    tick();
    chk("s_ack_pulse", ack,   4'b0000);
    chk("s_tx_en_hold", tx_en, 1);
    tick();
    tx_status = 1'b0;
    tick();
    chk("s_tx_en_fall", tx_en, 0);
    chk("s_owner_send", owner, 4'b0001);
    tick();
    chk("s_busy_send", busy, 1);
    tx_status = 1'b1;
    tick();
    chk("s_busy_done",  busy,  0);
    chk("s_owner_done", owner, 4'b0000);
    tick();
    chk("s_no_ack_idle", ack, 4'b0000);

    // Fairness
    do_reset();
    req      = 4'b1111;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("f_ack",     ack,     32'(1 << (i % 4)));
      chk("f_tx_data", tx_data, 32'(8'h10 + 8'h11 * (i % 4)));
      tx_status = 1'b0;
      tick();
      chk("f_ack_pulse", ack, 4'b0000);
      tx_status = 1'b1;
      tick();
      chk("f_idle", busy, 0);
    end

    // Streaming requester 0 plus newcomer 2
    do_reset();
    req      = 4'b0001;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    tick();
    chk("n_ack0", ack, 4'b0001);
    tx_status = 1'b0;
    tick();
    req = 4'b0101;
    tick();
    tx_status = 1'b1;
    tick();
    chk("n_idle", busy, 0);
    tick();
    chk("n_ack2",  ack,     4'b0100);
    chk("n_data2", tx_data, 8'hC2);
    req = 4'b0001;
    tx_status = 1'b0;
    tick();
    tx_status = 1'b1;
    tick();
    tick();
    chk("n_ack0b",  ack,     4'b0001);
    chk("n_data0b", tx_data, 8'hA0);

    // Timeout: transmitter never leaves idle
    req = 4'b0000;
    ack_cnt = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (ack != 4'b0000) ack_cnt++;
    end
    chk("t_tx_en_pre", tx_en, 1);
    chk("t_busy_pre",  busy,  1);
    chk("t_err_pre",   err,   0);
    err_clr = 1'b1;
    tick();
    chk("t_err_wins", err,   1);
    chk("t_tx_en",    tx_en, 0);
    chk("t_busy",     busy,  0);
    chk("t_owner",    owner, 4'b0000);
    chk("t_no_reack", ack_cnt + int'(ack != 4'b0000), 0);
    err_clr = 1'b0;
    tick();
    chk("t_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    chk("t_err_clr", err, 0);
    err_clr = 1'b0;

    // Transmitter busy when a request arrives
    tx_status = 1'b0;
    req       = 4'b0010;
    req_data  = {8'h7E, 8'h00, 8'h5B, 8'h00};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_no_ack",  ack,  4'b0000);
      chk("b_no_busy", busy, 0);
    end
    tx_status = 1'b1;
    tick();
    chk("b_ack",   ack,     4'b0010);
    chk("b_data",  tx_data, 8'h5B);
    chk("b_tx_en", tx_en,   1);
    tx_status = 1'b0;
    tick();
    chk("b_send_tx_en", tx_en, 0);
    chk("b_send_busy",  busy,  1);

    // Reset mid-SEND
    req = 4'b1000;
    #3;
    reset = 1'b0;
    #1;
    chk("r_tx_en", tx_en, 0);
    chk("r_ack",   ack,   4'b0000);
    chk("r_owner", owner, 4'b0000);
    chk("r_busy",  busy,  0);
    tick();
    reset = 1'b1;
    tick();
    chk("r_wait_ack", ack, 4'b0000);
    tick();
    chk("r_wait_ack2", ack, 4'b0000);
    tx_status = 1'b1;
    tick();
    chk("r_ack3",   ack,     4'b1000);
    chk("r_data3",  tx_data, 8'h7E);
    chk("r_owner3", owner,   4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
